// File: rtl/page_stream_queue_pkg.sv
// Shared definitions for the page stream queue: the stored-word layout and a
// constant-evaluable clog2 used to size pointers and the level port.
package page_stream_queue_pkg;

    // Position of the end-of-stream flag in a stored word; data occupies the bits above it.
    localparam int unsigned E_BIT = 0;
    localparam int unsigned D_LSB = E_BIT + 1;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int unsigned ps_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/page_stream_qmem.sv
// Token storage for the page stream queue: DEPTH x WW register array.
// Ports: clock; we/waddr/wdata write port; raddr -> rdata_c asynchronous read.
// The array contents are not reset. Validity is tracked by the owner's count.
module page_stream_qmem #(
    parameter int unsigned WW    = 17,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata_c
);

    logic [WW-1:0] mem [DEPTH];

    // Single write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port.
    assign rdata_c = mem[raddr];

endmodule

// File: rtl/page_stream_queue.sv
// Single-clock FIFO for one TDF page stream (d, e, v, b) with first-word
// fall-through, back-pressure slack, level reporting and sticky overflow.
// Ports: clock, reset (async active-low); in_d/in_e/in_v from the producer,
// in_b back-pressure to it; out_d/out_e/out_v head token, out_b consumer
// back-pressure; level = tokens stored; ovf = token was dropped since reset.
module page_stream_queue
    import page_stream_queue_pkg::*;
#(
    parameter  int unsigned WIDTH    = 16,
    parameter  int unsigned DEPTH    = 4,
    parameter  int unsigned BP_SLACK = 1,
    localparam int unsigned LW       = ps_clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_d,
    input  logic             in_e,
    input  logic             in_v,
    output logic             in_b,
    output logic [WIDTH-1:0] out_d,
    output logic             out_e,
    output logic             out_v,
    input  logic             out_b,
    output logic [LW-1:0]    level,
    output logic             ovf
);

    localparam int unsigned PW = ps_clog2(DEPTH);
    localparam int unsigned WW = WIDTH + 1;

    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [LW-1:0] count, count_n;
    logic          rd_c, wr_c, bypass_c;
    logic          in_b_n, ovf_n;
    logic [WW-1:0] wdata_c, rdata_c, head_c;

    // Pointer advance with wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wdata_c = {in_d, in_e};

    page_stream_qmem #(
        .WW    (WW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_qmem (
        .clock   (clock),
        .we      (wr_c),
        .waddr   (wr_ptr),
        .wdata   (wdata_c),
        .raddr   (rd_ptr_n),
        .rdata_c (rdata_c)
    );

    // Handshake, next pointers/count, and next head token.
    always_comb begin
        rd_c     = out_v & ~out_b;
        wr_c     = in_v & ((count < LW'(DEPTH)) | rd_c);
        count_n  = count + LW'(wr_c) - LW'(rd_c);
        wr_ptr_n = wr_c ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_n = rd_c ? ptr_inc(rd_ptr) : rd_ptr;
        // Queue is empty after this cycle's read: the incoming token becomes the head.
        bypass_c = wr_c & (count == LW'(rd_c));
        head_c   = bypass_c ? wdata_c : rdata_c;
        in_b_n   = (LW'(DEPTH) - count_n) <= LW'(BP_SLACK);
        ovf_n    = ovf | (in_v & (count == LW'(DEPTH)) & ~rd_c);
    end

    // State and registered outputs; out_d/out_e hold the last head when empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            out_v  <= 1'b0;
            out_d  <= '0;
            out_e  <= 1'b0;
            in_b   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            out_v  <= (count_n != '0);
            in_b   <= in_b_n;
            ovf    <= ovf_n;
            if (count_n != '0) begin
                out_d <= head_c[WW-1:D_LSB];
                out_e <= head_c[E_BIT];
            end
        end
    end

    assign level = count;

endmodule

// File: tb/tb_page_stream_queue.sv
module tb_page_stream_queue;

    logic clk;
    logic rst_n;

    // DUT A: WIDTH=16, DEPTH=4, BP_SLACK=1
    logic [15:0] a_in_d, a_out_d;
    logic        a_in_e, a_in_v, a_in_b, a_out_e, a_out_v, a_out_b, a_ovf;
    logic [2:0]  a_level;

    // DUT B: WIDTH=8, DEPTH=5, BP_SLACK=0
    logic [7:0]  b_in_d, b_out_d;
    logic        b_in_e, b_in_v, b_in_b, b_out_e, b_out_v, b_out_b, b_ovf;
    logic [2:0]  b_level;

    int n_cmp;
    int n_err;

    page_stream_queue #(.WIDTH(16), .DEPTH(4), .BP_SLACK(1)) dut_a (
        .clock (clk),     .reset (rst_n),
        .in_d  (a_in_d),  .in_e  (a_in_e),  .in_v  (a_in_v),  .in_b (a_in_b),
        .out_d (a_out_d), .out_e (a_out_e), .out_v (a_out_v), .out_b (a_out_b),
        .level (a_level), .ovf   (a_ovf)
    );

    page_stream_queue #(.WIDTH(8), .DEPTH(5), .BP_SLACK(0)) dut_b (
        .clock (clk),     .reset (rst_n),
        .in_d  (b_in_d),  .in_e  (b_in_e),  .in_v  (b_in_v),  .in_b (b_in_b),
        .out_d (b_out_d), .out_e (b_out_e), .out_v (b_out_v), .out_b (b_out_b),
        .level (b_level), .ovf   (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        e;
        logic        b;
        logic [2:0]  lvl;
        logic        ib;
        logic        ov;
        logic [15:0] od;
        logic        oe;
        logic        of;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [15:0] d, input logic e, input logic b,
                                input logic [2:0] lvl, input logic ib, input logic ov,
                                input logic [15:0] od, input logic oe, input logic of);
        vec_t r;
        r.v = v; r.d = d; r.e = e; r.b = b;
        r.lvl = lvl; r.ib = ib; r.ov = ov; r.od = od; r.oe = oe; r.of = of;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard state for DUT B
    logic [8:0] sb_q[$];
    logic       sb_ovf;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_in_d = '0; a_in_e = 1'b0; a_in_v = 1'b0; a_out_b = 1'b1;
        b_in_d = '0; b_in_e = 1'b0; b_in_v = 1'b0; b_out_b = 1'b1;

        //          v  d         e  b   lvl ib ov od        oe of
        vecs[0]  = mk(1, 16'h0001, 0, 1, 3'd1, 0, 1, 16'h0001, 0, 0);
        vecs[1]  = mk(1, 16'h0002, 0, 1, 3'd2, 0, 1, 16'h0001, 0, 0);
        vecs[2]  = mk(1, 16'h0003, 0, 1, 3'd3, 1, 1, 16'h0001, 0, 0);
        vecs[3]  = mk(1, 16'h0004, 0, 1, 3'd4, 1, 1, 16'h0001, 0, 0);
        vecs[4]  = mk(1, 16'h0005, 0, 0, 3'd4, 1, 1, 16'h0002, 0, 0);
        vecs[5]  = mk(1, 16'h0006, 0, 1, 3'd4, 1, 1, 16'h0002, 0, 1);
        vecs[6]  = mk(0, 16'h0000, 0, 0, 3'd3, 1, 1, 16'h0003, 0, 1);
        vecs[7]  = mk(0, 16'h0000, 0, 0, 3'd2, 0, 1, 16'h0004, 0, 1);
        vecs[8]  = mk(0, 16'h0000, 0, 0, 3'd1, 0, 1, 16'h0005, 0, 1);
        vecs[9]  = mk(0, 16'h0000, 0, 0, 3'd0, 0, 0, 16'h0005, 0, 1);
        vecs[10] = mk(0, 16'h0000, 0, 0, 3'd0, 0, 0, 16'h0005, 0, 1);
        vecs[11] = mk(1, 16'hABCD, 1, 0, 3'd1, 0, 1, 16'hABCD, 1, 1);
        vecs[12] = mk(1, 16'h1111, 0, 0, 3'd1, 0, 1, 16'h1111, 0, 1);
        vecs[13] = mk(1, 16'h2222, 0, 0, 3'd1, 0, 1, 16'h2222, 0, 1);
        vecs[14] = mk(0, 16'h0000, 0, 1, 3'd1, 0, 1, 16'h2222, 0, 1);
        vecs[15] = mk(0, 16'h0000, 0, 0, 3'd0, 0, 0, 16'h2222, 0, 1);

        // Reset state while reset is held
        #12;
        chk("rst level", 32'(a_level), 32'd0);
        chk("rst out_v", 32'(a_out_v), 32'd0);
        chk("rst in_b",  32'(a_in_b),  32'd0);
        chk("rst ovf",   32'(a_ovf),   32'd0);
        chk("rst out_d", 32'(a_out_d), 32'd0);
        chk("rst out_e", 32'(a_out_e), 32'd0);
        chk("rst b level", 32'(b_level), 32'd0);
        #10;
        rst_n = 1'b1;
        step();

        // Directed vector table on DUT A
        for (int i = 0; i < 16; i++) begin
            a_in_v = vecs[i].v; a_in_d = vecs[i].d; a_in_e = vecs[i].e; a_out_b = vecs[i].b;
            step();
            chk($sformatf("vec%0d level", i), 32'(a_level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d in_b", i),  32'(a_in_b),  32'(vecs[i].ib));
            chk($sformatf("vec%0d out_v", i), 32'(a_out_v), 32'(vecs[i].ov));
            chk($sformatf("vec%0d out_d", i), 32'(a_out_d), 32'(vecs[i].od));
            chk($sformatf("vec%0d out_e", i), 32'(a_out_e), 32'(vecs[i].oe));
            chk($sformatf("vec%0d ovf", i),   32'(a_ovf),   32'(vecs[i].of));
        end

        // Continuous streaming: one token per cycle, level never above 1
        a_out_b = 1'b0;
        a_in_e  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a_in_v = 1'b1;
            a_in_d = 16'h0100 + 16'(i);
            step();
            chk($sformatf("stream%0d level", i), 32'(a_level), 32'd1);
            chk($sformatf("stream%0d out_v", i), 32'(a_out_v), 32'd1);
            chk($sformatf("stream%0d out_d", i), 32'(a_out_d), 32'h0100 + 32'(i));
        end
        a_in_v = 1'b0;
        step();
        chk("stream drain level", 32'(a_level), 32'd0);

        // Fill to 3, then async reset mid-cycle
        a_out_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_v = 1'b1;
            a_in_d = 16'h000A + 16'(i);
            step();
        end
        a_in_v = 1'b0;
        chk("pre-rst level", 32'(a_level), 32'd3);
        chk("pre-rst in_b",  32'(a_in_b),  32'd1);
        chk("pre-rst ovf",   32'(a_ovf),   32'd1);
        chk("pre-rst out_d", 32'(a_out_d), 32'h000A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst level", 32'(a_level), 32'd0);
        chk("async rst out_v", 32'(a_out_v), 32'd0);
        chk("async rst ovf",   32'(a_ovf),   32'd0);
        chk("async rst in_b",  32'(a_in_b),  32'd0);
        chk("async rst out_d", 32'(a_out_d), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        a_in_v = 1'b1; a_in_d = 16'h0077;
        step();
        a_in_v = 1'b0;
        chk("post-rst level", 32'(a_level), 32'd1);
        chk("post-rst out_d", 32'(a_out_d), 32'h0077);
        chk("post-rst out_v", 32'(a_out_v), 32'd1);
        chk("post-rst ovf",   32'(a_ovf),   32'd0);

        // DUT B: DEPTH=5, BP_SLACK=0, random traffic against a queue scoreboard
        sb_q.delete();
        sb_ovf = 1'b0;
        for (int c = 0; c < 300; c++) begin
            logic iv, ob, rd, wr;
            logic [8:0] tok;
            iv = ($urandom_range(0, 3) != 0);
            if (c < 60)       ob = ($urandom_range(0, 3) != 0);
            else if (c < 120) ob = ($urandom_range(0, 3) == 0);
            else              ob = ($urandom_range(0, 1) == 0);
            tok = 9'($urandom_range(0, 511));
            b_in_v = iv; b_out_b = ob; b_in_d = tok[8:1]; b_in_e = tok[0];
            rd = (sb_q.size() != 0) && !ob;
            wr = iv && ((sb_q.size() < 5) || rd);
            if (iv && (sb_q.size() == 5) && !rd) sb_ovf = 1'b1;
            step();
            if (rd) void'(sb_q.pop_front());
            if (wr) sb_q.push_back(tok);
            chk($sformatf("sb%0d level", c), 32'(b_level), 32'(sb_q.size()));
            chk($sformatf("sb%0d out_v", c), 32'(b_out_v), 32'(sb_q.size() != 0));
            chk($sformatf("sb%0d in_b", c),  32'(b_in_b),  32'(sb_q.size() == 5));
            chk($sformatf("sb%0d ovf", c),   32'(b_ovf),   32'(sb_ovf));
            if (sb_q.size() != 0) begin
                chk($sformatf("sb%0d out_d", c), 32'(b_out_d), 32'(sb_q[0][8:1]));
                chk($sformatf("sb%0d out_e", c), 32'(b_out_e), 32'(sb_q[0][0]));
            end
        end
        b_in_v = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
